// File: rtl/fir_coeff_pkg.sv
// fir_coeff_pkg: shared constants, state type and address helper for the FIR
// coefficient loader and its RAM bus register stage.
package fir_coeff_pkg;

  localparam int unsigned NUM_TAPS  = 33;  // coefficients per load
  localparam int unsigned BASE_ADDR = 2;   // RAM address of tap 1
  localparam int unsigned DATA_W    = 16;  // coefficient width
  localparam int unsigned ADDR_W    = 6;   // RAM address width

  // StCheck is only reachable when COEFF_CHECKSUM_EN is defined.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StWrite = 3'd1,
    StRead  = 3'd2,
    StDone  = 3'd3,
    StCheck = 3'd4
  } loaderState_t;

  // RAM address of zero-based tap k (unsigned, wraps at ADDR_W bits).
  function automatic logic [ADDR_W-1:0] tapAddr(input logic [ADDR_W-1:0] k);
    return ADDR_W'(BASE_ADDR) + k;
  endfunction

endpackage

// File: rtl/fir_coeff_ram_if.sv
// fir_coeff_ram_if: registers the coefficient-RAM bus from the loader FSM's
// per-cycle command. With no command the bus is driven idle (deselected, read,
// address and data zero).
//
// Ports:
//   iClk_12M  - system clock
//   iRsn      - asynchronous active-low reset
//   iCmdEn    - a RAM access is requested this cycle
//   iCmdWr    - 1 = write access, 0 = read access
//   iCmdAddr  - access address
//   iCmdData  - write data (ignored for reads)
//   oCsnRam   - registered chip select, active low
//   oWrnRam   - registered write enable, active low
//   oAddrRam  - registered address
//   oWrDtRam  - registered write data
module fir_coeff_ram_if
  import fir_coeff_pkg::*;
(
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iCmdEn,
  input  logic              iCmdWr,
  input  logic [ADDR_W-1:0] iCmdAddr,
  input  logic [DATA_W-1:0] iCmdData,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam
);

  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
      oAddrRam <= '0;
      oWrDtRam <= '0;
    end else if (iCmdEn) begin
      oCsnRam  <= 1'b0;
      oWrnRam  <= ~iCmdWr;
      oAddrRam <= iCmdAddr;
      oWrDtRam <= iCmdWr ? iCmdData : '0;
    end else begin
      oCsnRam  <= 1'b1;
      oWrnRam  <= 1'b1;
      oAddrRam <= '0;
      oWrDtRam <= '0;
    end
  end

endmodule

// File: rtl/fir_coeff_loader.sv
// fir_coeff_loader: accepts NUM_TAPS signed coefficients over a valid/ready
// stream, writes them to the FIR coefficient SRAM at BASE_ADDR.., then sweeps
// the same addresses with 2-cycle reads so the filter latches every tap.
// The update flag covers the whole write+read sequence.
//
// Optional feature: define COEFF_CHECKSUM_EN to accept one extra word after
// the coefficients; it must equal their modulo-2^16 sum, otherwise oErr is set
// and the read sweep is skipped. Without the macro oErr is tied low.
//
// Ports:
//   iClk_12M          - system clock
//   iRsn              - asynchronous active-low reset
//   iLoadStart        - start request, honoured only when idle
//   iAbort            - synchronous abort to idle from any state
//   iCoeffValid       - coefficient word valid
//   iCoeffDt          - coefficient word
//   oCoeffReady       - loader accepts a word this cycle
//   oCoeffiUpdateFlag - high for the whole write+read sequence
//   oCsnRam/oWrnRam/oAddrRam/oWrDtRam - registered coefficient-RAM bus
//   oBusy             - high whenever the loader is not idle
//   oDone             - one-cycle pulse when a load completes
//   oErr              - sticky checksum error, cleared by the next load start
module fir_coeff_loader
  import fir_coeff_pkg::*;
(
  input  logic              iClk_12M,
  input  logic              iRsn,
  input  logic              iLoadStart,
  input  logic              iAbort,
  input  logic              iCoeffValid,
  input  logic [DATA_W-1:0] iCoeffDt,
  output logic              oCoeffReady,
  output logic              oCoeffiUpdateFlag,
  output logic              oCsnRam,
  output logic              oWrnRam,
  output logic [ADDR_W-1:0] oAddrRam,
  output logic [DATA_W-1:0] oWrDtRam,
  output logic              oBusy,
  output logic              oDone,
  output logic              oErr
);

  localparam logic [ADDR_W-1:0] LastTap = ADDR_W'(NUM_TAPS - 1);

  if (BASE_ADDR + NUM_TAPS - 1 > (2 ** ADDR_W) - 1) begin : gAddrRangeCheck
    $error("fir_coeff_loader: coefficient addresses exceed the RAM address range");
  end

  loaderState_t      stateQ, stateD;
  logic [ADDR_W-1:0] kQ, kD;
  logic              phaseQ, phaseD;   // second cycle of a 2-cycle tap read
  logic              readyQ, activeQ, doneQ;
  logic              handshake;

  logic              cmdEn, cmdWr;
  logic [ADDR_W-1:0] cmdAddr;
  logic [DATA_W-1:0] cmdData;

`ifdef COEFF_CHECKSUM_EN
  logic [DATA_W-1:0] sumQ, sumD;
  logic              errQ, errD;
`endif

  assign handshake = iCoeffValid && readyQ;

  always_comb begin
    stateD  = stateQ;
    kD      = kQ;
    phaseD  = phaseQ;
    cmdEn   = 1'b0;
    cmdWr   = 1'b0;
    cmdAddr = '0;
    cmdData = '0;
`ifdef COEFF_CHECKSUM_EN
    sumD    = sumQ;
    errD    = errQ;
`endif

    unique case (stateQ)
      StIdle: begin
        if (iLoadStart) begin
          stateD = StWrite;
          kD     = '0;
          phaseD = 1'b0;
`ifdef COEFF_CHECKSUM_EN
          sumD   = '0;
          errD   = 1'b0;
`endif
        end
      end

      StWrite: begin
        if (handshake) begin
          cmdEn   = 1'b1;
          cmdWr   = 1'b1;
          cmdAddr = tapAddr(kQ);
          cmdData = iCoeffDt;
`ifdef COEFF_CHECKSUM_EN
          sumD    = sumQ + iCoeffDt;
`endif
          if (kQ == LastTap) begin
            kD     = '0;
            phaseD = 1'b0;
`ifdef COEFF_CHECKSUM_EN
            stateD = StCheck;
`else
            stateD = StRead;
`endif
          end else begin
            kD = kQ + ADDR_W'(1);
          end
        end
      end

`ifdef COEFF_CHECKSUM_EN
      StCheck: begin
        if (handshake) begin
          if (iCoeffDt != sumQ) begin
            errD   = 1'b1;
            stateD = StDone;
          end else begin
            stateD = StRead;
          end
        end
      end
`endif

      StRead: begin
        // Address is held two cycles so the synchronous RAM read lands
        // before the filter latches the tap.
        cmdEn   = 1'b1;
        cmdAddr = tapAddr(kQ);
        phaseD  = ~phaseQ;
        if (phaseQ) begin
          if (kQ == LastTap) begin
            kD     = '0;
            stateD = StDone;
          end else begin
            kD = kQ + ADDR_W'(1);
          end
        end
      end

      StDone: stateD = StIdle;

      default: stateD = StIdle;
    endcase

    if (iAbort) begin
      stateD  = StIdle;
      cmdEn   = 1'b0;
      cmdWr   = 1'b0;
      cmdAddr = '0;
      cmdData = '0;
    end
  end

  // Status outputs are registered from the next state so they line up with
  // the state itself; the RAM bus lags its command by one register stage.
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      stateQ  <= StIdle;
      kQ      <= '0;
      phaseQ  <= 1'b0;
      readyQ  <= 1'b0;
      activeQ <= 1'b0;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      kQ      <= kD;
      phaseQ  <= phaseD;
      readyQ  <= (stateD == StWrite) || (stateD == StCheck);
      activeQ <= (stateD != StIdle);
      doneQ   <= (stateQ == StDone) && !iAbort;
    end
  end

`ifdef COEFF_CHECKSUM_EN
  always_ff @(posedge iClk_12M or negedge iRsn) begin
    if (!iRsn) begin
      sumQ <= '0;
      errQ <= 1'b0;
    end else begin
      sumQ <= sumD;
      errQ <= errD;
    end
  end
  assign oErr = errQ;
`else
  assign oErr = 1'b0;
`endif

  assign oCoeffReady       = readyQ;
  assign oCoeffiUpdateFlag = activeQ;
  assign oBusy             = activeQ;
  assign oDone             = doneQ;

  fir_coeff_ram_if uRamIf (
    .iClk_12M (iClk_12M),
    .iRsn     (iRsn),
    .iCmdEn   (cmdEn),
    .iCmdWr   (cmdWr),
    .iCmdAddr (cmdAddr),
    .iCmdData (cmdData),
    .oCsnRam  (oCsnRam),
    .oWrnRam  (oWrnRam),
    .oAddrRam (oAddrRam),
    .oWrDtRam (oWrDtRam)
  );

endmodule

// File: tb/tb_fir_coeff_loader.sv
// Directed self-checking bench for fir_coeff_loader. Cycle 0 is the cycle in
// which iLoadStart is driven; outputs are sampled 1 time unit after each edge.
module tb_fir_coeff_loader;
  import fir_coeff_pkg::*;

`ifdef COEFF_CHECKSUM_EN
  localparam int E = 1;  // extra CHECK cycle shifts everything after the writes
`else
  localparam int E = 0;
`endif

  logic        iClk_12M = 1'b0;
  logic        iRsn = 1'b0;
  logic        iLoadStart = 1'b0;
  logic        iAbort = 1'b0;
  logic        iCoeffValid = 1'b0;
  logic [15:0] iCoeffDt = '0;
  logic        oCoeffReady, oCoeffiUpdateFlag, oCsnRam, oWrnRam, oBusy, oDone, oErr;
  logic [5:0]  oAddrRam;
  logic [15:0] oWrDtRam;
  logic [28:0] obs;

  int nCompared = 0;
  int nMismatched = 0;

  localparam logic [28:0] ResetVec = {5'b00000, 1'b1, 1'b1, 6'd0, 16'd0};

  always #5 iClk_12M = ~iClk_12M;

  fir_coeff_loader dut (
    .iClk_12M          (iClk_12M),
    .iRsn              (iRsn),
    .iLoadStart        (iLoadStart),
    .iAbort            (iAbort),
    .iCoeffValid       (iCoeffValid),
    .iCoeffDt          (iCoeffDt),
    .oCoeffReady       (oCoeffReady),
    .oCoeffiUpdateFlag (oCoeffiUpdateFlag),
    .oCsnRam           (oCsnRam),
    .oWrnRam           (oWrnRam),
    .oAddrRam          (oAddrRam),
    .oWrDtRam          (oWrDtRam),
    .oBusy             (oBusy),
    .oDone             (oDone),
    .oErr              (oErr)
  );

  // {ready, flag, busy, done, err, csn, wrn, addr, data}
  assign obs = {oCoeffReady, oCoeffiUpdateFlag, oBusy, oDone, oErr,
                oCsnRam, oWrnRam, oAddrRam, oWrDtRam};

  task automatic tick;
    @(posedge iClk_12M);
    #1;
  endtask

  // Word presented in cycle c of a load with valid held high: 1..33, then the
  // checksum 1+..+33 = 561.
  function automatic logic [15:0] wordFull(input int c);
    if (c >= 1 && c <= 33) return 16'(c);
    if (c == 34) return 16'd561;
    return 16'd0;
  endfunction

  // Hand-derived output vector for cycle c of a valid-held-high load.
  function automatic logic [28:0] expFull(input int c);
    logic rdy, act, dn, csn, wrn;
    logic [5:0] addr;
    logic [15:0] data;
    rdy  = (c >= 1 && c <= 33 + E);
    act  = (c >= 1 && c <= 100 + E);
    dn   = (c == 101 + E);
    csn  = 1'b1;
    wrn  = 1'b1;
    addr = '0;
    data = '0;
    if (c >= 2 && c <= 34) begin
      csn  = 1'b0;
      wrn  = 1'b0;
      addr = 6'(c);
      data = 16'(c - 1);
    end else if (c >= 35 + E && c <= 100 + E) begin
      csn  = 1'b0;
      addr = 6'(2 + (c - 35 - E) / 2);
    end
    return {rdy, act, act, dn, 1'b0, csn, wrn, addr, data};
  endfunction

  // Full load with valid held high, every cycle compared; optional stray start.
  task automatic run_load_checked(input int pulseAt, input string tag);
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b1;
    iCoeffDt    = '0;
    tick;
    iLoadStart = 1'b0;
    for (int c = 1; c <= 110; c++) begin
      nCompared++;
      if (obs !== expFull(c)) begin
        nMismatched++;
        $display("FAIL %s cycle %0d: got %h want %h", tag, c, obs, expFull(c));
      end
      iCoeffDt   = wordFull(c);
      iLoadStart = (c == pulseAt);
      tick;
    end
    iLoadStart  = 1'b0;
    iCoeffValid = 1'b0;
  endtask

  task automatic test_reset;
    iRsn = 1'b0;
    tick;
    tick;
    nCompared++;
    if (obs !== ResetVec) begin
      nMismatched++;
      $display("FAIL reset_hold: got %h want %h", obs, ResetVec);
    end
    iRsn = 1'b1;
    tick;
    tick;
    nCompared++;
    if (obs !== ResetVec) begin
      nMismatched++;
      $display("FAIL reset_idle: got %h want %h", obs, ResetVec);
    end
  endtask

  task automatic test_full_load;
    run_load_checked(-1, "full_load");
  endtask

  task automatic test_start_ignored;
    run_load_checked(10, "start_ignored");
  endtask

  task automatic test_valid_toggle;
    int sent = 0, writes = 0, reads = 0, doneAt = -1;
    logic prevHs = 1'b0, hs, wrSeen;
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b0;
    tick;
    iLoadStart = 1'b0;
    for (int c = 1; c <= 400 && doneAt < 0; c++) begin
      wrSeen = !oCsnRam && !oWrnRam;
      nCompared++;
      if (wrSeen !== prevHs) begin
        nMismatched++;
        $display("FAIL toggle_write_timing cycle %0d: got %b want %b", c, wrSeen, prevHs);
      end
      if (wrSeen) begin
        nCompared++;
        if ({oAddrRam, oWrDtRam} !== {6'(2 + writes), 16'(16'h0100 + writes)}) begin
          nMismatched++;
          $display("FAIL toggle_write_%0d: got addr %0d data %h want addr %0d data %h",
                   writes, oAddrRam, oWrDtRam, 2 + writes, 16'h0100 + writes);
        end
        writes++;
      end
      if (!oCsnRam && oWrnRam) reads++;
      if (oDone) doneAt = c;
      iCoeffValid = (c % 2 == 1);
      iCoeffDt    = (sent < 33) ? 16'(16'h0100 + sent) : 16'h2310;
      hs          = iCoeffValid && oCoeffReady;
      prevHs      = hs && (sent < 33);
      if (hs) sent++;
      tick;
    end
    iCoeffValid = 1'b0;
    nCompared++;
    if (writes !== 33) begin
      nMismatched++;
      $display("FAIL toggle_write_count: got %0d want 33", writes);
    end
    nCompared++;
    if (reads !== 66) begin
      nMismatched++;
      $display("FAIL toggle_read_count: got %0d want 66", reads);
    end
    nCompared++;
    if (doneAt !== 133 + 2 * E) begin
      nMismatched++;
      $display("FAIL toggle_done_cycle: got %0d want %0d", doneAt, 133 + 2 * E);
    end
    tick;
  endtask

  task automatic test_abort_read;
    int doneCnt = 0, csnLow = 0;
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b1;
    tick;
    iLoadStart = 1'b0;
    for (int c = 1; c <= 55 + E; c++) begin
      if (c == 55 + E) begin
        nCompared++;
        if (obs !== expFull(c)) begin
          nMismatched++;
          $display("FAIL abort_tap10_read: got %h want %h", obs, expFull(c));
        end
        iAbort = 1'b1;
      end
      iCoeffDt = wordFull(c);
      tick;
    end
    iAbort      = 1'b0;
    iCoeffValid = 1'b0;
    nCompared++;
    if (obs !== ResetVec) begin
      nMismatched++;
      $display("FAIL abort_idle_next: got %h want %h", obs, ResetVec);
    end
    for (int c = 0; c < 120; c++) begin
      if (oDone) doneCnt++;
      if (!oCsnRam) csnLow++;
      tick;
    end
    nCompared++;
    if (doneCnt !== 0) begin
      nMismatched++;
      $display("FAIL abort_no_done: got %0d pulses want 0", doneCnt);
    end
    nCompared++;
    if (csnLow !== 0) begin
      nMismatched++;
      $display("FAIL abort_bus_idle: got %0d active cycles want 0", csnLow);
    end
  endtask

`ifdef COEFF_CHECKSUM_EN
  task automatic run_chk(input logic [15:0] chk, input logic expErr, input string tag);
    int reads = 0, doneAt = -1;
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b1;
    tick;
    iLoadStart = 1'b0;
    for (int c = 1; c <= 130; c++) begin
      if (!oCsnRam && oWrnRam) reads++;
      if (oDone && doneAt < 0) doneAt = c;
      iCoeffDt = (c <= 33) ? 16'h1000 : chk;
      tick;
    end
    iCoeffValid = 1'b0;
    nCompared++;
    if (reads !== (expErr ? 0 : 66)) begin
      nMismatched++;
      $display("FAIL %s_reads: got %0d want %0d", tag, reads, expErr ? 0 : 66);
    end
    nCompared++;
    if (doneAt !== (expErr ? 36 : 102)) begin
      nMismatched++;
      $display("FAIL %s_done_cycle: got %0d want %0d", tag, doneAt, expErr ? 36 : 102);
    end
    nCompared++;
    if (oErr !== expErr) begin
      nMismatched++;
      $display("FAIL %s_err: got %b want %b", tag, oErr, expErr);
    end
  endtask

  task automatic test_checksum;
    run_chk(16'h1000, 1'b0, "chk_match");
    run_chk(16'h0000, 1'b1, "chk_bad");
    iLoadStart = 1'b1;
    tick;
    iLoadStart = 1'b0;
    nCompared++;
    if (oErr !== 1'b0) begin
      nMismatched++;
      $display("FAIL chk_err_clear: got %b want 0", oErr);
    end
    iAbort = 1'b1;
    tick;
    iAbort = 1'b0;
    tick;
  endtask
`endif

  task automatic test_reset_midload;
    iLoadStart  = 1'b1;
    iCoeffValid = 1'b1;
    tick;
    iLoadStart = 1'b0;
    for (int c = 1; c <= 17; c++) begin
      iCoeffDt = wordFull(c);
      tick;
    end
    nCompared++;
    if (obs !== expFull(18)) begin
      nMismatched++;
      $display("FAIL midload_write17: got %h want %h", obs, expFull(18));
    end
    #2;
    iRsn = 1'b0;
    #1;
    nCompared++;
    if (obs !== ResetVec) begin
      nMismatched++;
      $display("FAIL midload_async_reset: got %h want %h", obs, ResetVec);
    end
    iCoeffValid = 1'b0;
    tick;
    tick;
    iRsn = 1'b1;
    tick;
    nCompared++;
    if (obs !== ResetVec) begin
      nMismatched++;
      $display("FAIL midload_after_release: got %h want %h", obs, ResetVec);
    end
    run_load_checked(-1, "reload_after_reset");
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_valid_toggle();
    test_abort_read();
    test_start_ignored();
`ifdef COEFF_CHECKSUM_EN
    test_checksum();
`endif
    test_reset_midload();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
